// File: rtl/ahb_boot_arbiter.sv
// Two-master AHB-Lite arbiter: the SPI boot loader (M0) owns the bus until boot_hold falls, then the RISC-V core (M1) takes over and leaves reset.
// Optional build macro ARB_WRITE_PROTECT_EN blocks core writes below PROT_LIMIT and flags them on prot_err.
module ahb_boot_arbiter #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter logic [31:0] PROT_LIMIT  = 32'h200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        boot_hold,
   input  logic [31:0] m0_haddr,
   input  logic [1:0]  m0_htrans,
   input  logic        m0_hwrite,
   input  logic [2:0]  m0_hsize,
   input  logic [31:0] m0_hwdata,
   output logic        m0_hready,
   input  logic [31:0] m1_haddr,
   input  logic [1:0]  m1_htrans,
   input  logic        m1_hwrite,
   input  logic [2:0]  m1_hsize,
   input  logic [31:0] m1_hwdata,
   output logic        m1_hready,
   output logic [31:0] m1_hrdata,
   output logic        m1_hresp,
   output logic [31:0] s_haddr,
   output logic [1:0]  s_htrans,
   output logic        s_hwrite,
   output logic [2:0]  s_hsize,
   output logic [31:0] s_hwdata,
   input  logic        s_hready,
   input  logic        s_hresp,
   input  logic [31:0] s_hrdata,
   output logic        core_rst_n,
   output logic        prot_err
);

   typedef enum logic [1:0] {
      BOOT  = 2'b00,
      DRAIN = 2'b01,
      HOLD  = 2'b10,
      RUN   = 2'b11
   } state_t;

   localparam logic [1:0] TRANS_IDLE = 2'b00;
   localparam logic [1:0] TRANS_SEQ  = 2'b11;
   localparam logic       OWNER_M0   = 1'b0;
   localparam logic       OWNER_M1   = 1'b1;
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic       addr_owner;
   logic       addr_owner_nxt;
   logic       dp_owner;
   logic [7:0] hold_ctr;
   logic [7:0] hold_ctr_nxt;
   logic       core_rst_n_nxt;
   logic       blocked;

`ifdef ARB_WRITE_PROTECT_EN
   assign blocked = (state == RUN) && m1_htrans[1] && m1_hwrite && (m1_haddr < PROT_LIMIT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         prot_err <= 1'b0;
      end else if (blocked) begin
         prot_err <= 1'b1;
      end
   end
`else
   logic unused_prot_limit;

   assign blocked           = 1'b0;
   assign prot_err          = 1'b0;
   assign unused_prot_limit = ^PROT_LIMIT;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= BOOT;
         addr_owner <= OWNER_M0;
         dp_owner   <= OWNER_M0;
         hold_ctr   <= 8'd0;
         core_rst_n <= 1'b0;
      end else begin
         state      <= state_nxt;
         addr_owner <= addr_owner_nxt;
         hold_ctr   <= hold_ctr_nxt;
         core_rst_n <= core_rst_n_nxt;
         if (s_hready) begin
            dp_owner <= addr_owner;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      addr_owner_nxt = addr_owner;
      hold_ctr_nxt   = hold_ctr;
      core_rst_n_nxt = core_rst_n;
      s_htrans       = TRANS_IDLE;

      case (state)
         BOOT: begin
            addr_owner_nxt = OWNER_M0;
            // Only IDLE/NONSEQ are legal loader bursts; a stray SEQ is dropped, other encodings pass.
            s_htrans = (m0_htrans == TRANS_SEQ) ? TRANS_IDLE : m0_htrans;
            if (!boot_hold) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (s_hready) begin
               state_nxt    = HOLD;
               hold_ctr_nxt = 8'd0;
            end
         end
         HOLD: begin
            hold_ctr_nxt = hold_ctr + 8'd1;
            if (hold_ctr == HOLD_LAST) begin
               addr_owner_nxt = OWNER_M1;
               core_rst_n_nxt = 1'b1;
               state_nxt      = RUN;
            end
         end
         RUN: begin
            addr_owner_nxt = OWNER_M1;
            s_htrans       = blocked ? TRANS_IDLE : m1_htrans;
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase

      if (!reset) begin
         s_htrans = TRANS_IDLE;
      end
   end

   // Address/control follow the address owner; write data follows whoever owned the previous accepted phase.
   assign s_haddr  = (addr_owner == OWNER_M1) ? m1_haddr  : m0_haddr;
   assign s_hwrite = (addr_owner == OWNER_M1) ? m1_hwrite : m0_hwrite;
   assign s_hsize  = (addr_owner == OWNER_M1) ? m1_hsize  : m0_hsize;
   assign s_hwdata = (dp_owner == OWNER_M1)   ? m1_hwdata : m0_hwdata;

   assign m0_hready = (addr_owner == OWNER_M0) ? s_hready : (state != BOOT);
   assign m1_hready = (addr_owner == OWNER_M1) ? (blocked | s_hready) : 1'b0;
   assign m1_hresp  = (dp_owner == OWNER_M1) ? s_hresp : 1'b0;
   assign m1_hrdata = s_hrdata;

endmodule

// File: tb/tb_ahb_boot_arbiter.sv
// Directed bench for ahb_boot_arbiter: boot writes, handover timing, drain wait states, run traffic, write protect and mid-run reset.
module tb_ahb_boot_arbiter;

`ifdef ARB_WRITE_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   typedef struct {
      logic        bh;
      logic [31:0] m0_addr;
      logic [1:0]  m0_trans;
      logic        m0_write;
      logic [31:0] m0_wdata;
      logic [31:0] m1_addr;
      logic [1:0]  m1_trans;
      logic        m1_write;
      logic [31:0] m1_wdata;
      logic        rdy;
      logic        rsp;
      logic [31:0] rdata;
      logic [31:0] e_addr;
      logic [1:0]  e_trans;
      logic        e_write;
      logic [2:0]  e_size;
      logic [31:0] e_wdata;
      logic        e_m0_rdy;
      logic        e_m1_rdy;
      logic        e_m1_rsp;
      logic [31:0] e_rdata;
      logic        e_rst_n;
      logic        e_perr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        boot_hold;
   logic [31:0] m0_haddr;
   logic [1:0]  m0_htrans;
   logic        m0_hwrite;
   logic [2:0]  m0_hsize;
   logic [31:0] m0_hwdata;
   logic        m0_hready;
   logic [31:0] m1_haddr;
   logic [1:0]  m1_htrans;
   logic        m1_hwrite;
   logic [2:0]  m1_hsize;
   logic [31:0] m1_hwdata;
   logic        m1_hready;
   logic [31:0] m1_hrdata;
   logic        m1_hresp;
   logic [31:0] s_haddr;
   logic [1:0]  s_htrans;
   logic        s_hwrite;
   logic [2:0]  s_hsize;
   logic [31:0] s_hwdata;
   logic        s_hready;
   logic        s_hresp;
   logic [31:0] s_hrdata;
   logic        core_rst_n;
   logic        prot_err;

   int checks = 0;
   int errors = 0;

   vec_t boot_vecs [5];
   vec_t run_vecs  [10];

   always #5 clk = ~clk;

   ahb_boot_arbiter #(.HOLD_CYCLES(16), .PROT_LIMIT(32'h200)) dut (
      .clk        (clk),
      .reset      (reset),
      .boot_hold  (boot_hold),
      .m0_haddr   (m0_haddr),
      .m0_htrans  (m0_htrans),
      .m0_hwrite  (m0_hwrite),
      .m0_hsize   (m0_hsize),
      .m0_hwdata  (m0_hwdata),
      .m0_hready  (m0_hready),
      .m1_haddr   (m1_haddr),
      .m1_htrans  (m1_htrans),
      .m1_hwrite  (m1_hwrite),
      .m1_hsize   (m1_hsize),
      .m1_hwdata  (m1_hwdata),
      .m1_hready  (m1_hready),
      .m1_hrdata  (m1_hrdata),
      .m1_hresp   (m1_hresp),
      .s_haddr    (s_haddr),
      .s_htrans   (s_htrans),
      .s_hwrite   (s_hwrite),
      .s_hsize    (s_hsize),
      .s_hwdata   (s_hwdata),
      .s_hready   (s_hready),
      .s_hresp    (s_hresp),
      .s_hrdata   (s_hrdata),
      .core_rst_n (core_rst_n),
      .prot_err   (prot_err)
   );

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      boot_hold = v.bh;
      m0_haddr  = v.m0_addr;
      m0_htrans = v.m0_trans;
      m0_hwrite = v.m0_write;
      m0_hwdata = v.m0_wdata;
      m1_haddr  = v.m1_addr;
      m1_htrans = v.m1_trans;
      m1_hwrite = v.m1_write;
      m1_hwdata = v.m1_wdata;
      s_hready  = v.rdy;
      s_hresp   = v.rsp;
      s_hrdata  = v.rdata;
   endtask

   task automatic check_output(input vec_t v, input string tag);
      check_val({tag, " s_haddr"},    s_haddr,          v.e_addr);
      check_val({tag, " s_htrans"},   32'(s_htrans),    32'(v.e_trans));
      check_val({tag, " s_hwrite"},   32'(s_hwrite),    32'(v.e_write));
      check_val({tag, " s_hsize"},    32'(s_hsize),     32'(v.e_size));
      check_val({tag, " s_hwdata"},   s_hwdata,         v.e_wdata);
      check_val({tag, " m0_hready"},  32'(m0_hready),   32'(v.e_m0_rdy));
      check_val({tag, " m1_hready"},  32'(m1_hready),   32'(v.e_m1_rdy));
      check_val({tag, " m1_hresp"},   32'(m1_hresp),    32'(v.e_m1_rsp));
      check_val({tag, " m1_hrdata"},  m1_hrdata,        v.e_rdata);
      check_val({tag, " core_rst_n"}, 32'(core_rst_n),  32'(v.e_rst_n));
      check_val({tag, " prot_err"},   32'(prot_err),    32'(v.e_perr));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Boot phase: M1 keeps requesting 0x300 to show it never leaks through.
      boot_vecs[0] = '{1'b1, 32'h0,  2'b10, 1'b1, 32'h0,        32'h300, 2'b10, 1'b1, 32'h33333333, 1'b1, 1'b0, 32'h0,
                       32'h0,  2'b10, 1'b1, 3'd2, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      boot_vecs[1] = '{1'b1, 32'h4,  2'b10, 1'b1, 32'hDEADBEEF, 32'h300, 2'b10, 1'b1, 32'h33333333, 1'b1, 1'b0, 32'h0,
                       32'h4,  2'b10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      boot_vecs[2] = '{1'b1, 32'h4,  2'b00, 1'b0, 32'h12345678, 32'h300, 2'b10, 1'b1, 32'h33333333, 1'b1, 1'b1, 32'h0,
                       32'h4,  2'b00, 1'b0, 3'd2, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      boot_vecs[3] = '{1'b1, 32'h10, 2'b01, 1'b0, 32'h0,        32'h300, 2'b10, 1'b1, 32'h33333333, 1'b0, 1'b0, 32'h0,
                       32'h10, 2'b01, 1'b0, 3'd2, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      boot_vecs[4] = '{1'b1, 32'h0,  2'b00, 1'b0, 32'h0,        32'h300, 2'b10, 1'b1, 32'h33333333, 1'b1, 1'b0, 32'h0,
                       32'h0,  2'b00, 1'b0, 3'd2, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};

      // Run phase: loader keeps driving NONSEQ writes to 0x40 with boot_hold high; all of it must be ignored.
      run_vecs[0] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'h200, 2'b10, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,
                      32'h200, 2'b10, 1'b0, 3'd1, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
      run_vecs[1] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'h0,   2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D,
                      32'h0,   2'b00, 1'b0, 3'd1, 32'h0,        1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0};
      run_vecs[2] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'h204, 2'b10, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,
                      32'h204, 2'b10, 1'b1, 3'd1, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
      run_vecs[3] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'h204, 2'b00, 1'b0, 32'h11223344, 1'b1, 1'b1, 32'h0,
                      32'h204, 2'b00, 1'b0, 3'd1, 32'h11223344, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1, 1'b0};
      run_vecs[4] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'h208, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,
                      32'h208, 2'b10, 1'b0, 3'd1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
      run_vecs[5] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'h100, 2'b10, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,
                      32'h100, (PROT ? 2'b00 : 2'b10), 1'b1, 3'd1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
      run_vecs[6] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'h200, 2'b10, 1'b1, 32'h55,       1'b1, 1'b0, 32'h0,
                      32'h200, 2'b10, 1'b1, 3'd1, 32'h55,       1'b1, 1'b1, 1'b0, 32'h0,        1'b1, PROT};
      run_vecs[7] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'h100, 2'b10, 1'b0, 32'h66,       1'b1, 1'b0, 32'h0,
                      32'h100, 2'b10, 1'b0, 3'd1, 32'h66,       1'b1, 1'b1, 1'b0, 32'h0,        1'b1, PROT};
      run_vecs[8] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'hFC,  2'b11, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,
                      32'hFC,  (PROT ? 2'b00 : 2'b11), 1'b1, 3'd1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, PROT};
      run_vecs[9] = '{1'b1, 32'h40, 2'b10, 1'b1, 32'h44444444, 32'h0,   2'b00, 1'b0, 32'h77,       1'b1, 1'b0, 32'h0,
                      32'h0,   2'b00, 1'b0, 3'd1, 32'h77,       1'b1, 1'b1, 1'b0, 32'h0,        1'b1, PROT};

      m0_hsize = 3'd2;
      m1_hsize = 3'd1;
      reset    = 1'b0;
      apply_stimulus(boot_vecs[0]);

      // Reset state: loader NONSEQ must not reach the slave while reset is held.
      repeat (2) @(posedge clk);
      #1;
      check_val("reset s_htrans",   32'(s_htrans),   32'h0);
      check_val("reset core_rst_n", 32'(core_rst_n), 32'h0);
      check_val("reset prot_err",   32'(prot_err),   32'h0);
      check_val("reset m1_hready",  32'(m1_hready),  32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         apply_stimulus(boot_vecs[i]);
         #1;
         check_output(boot_vecs[i], $sformatf("boot%0d", i));
      end

      // Handover with a ready slave: core_rst_n rises on the 17th edge after the one that sees boot_hold low.
      @(negedge clk);
      boot_hold = 1'b0;
      m0_haddr  = 32'h80;
      m0_htrans = 2'b10;
      m0_hwrite = 1'b1;
      m1_haddr  = 32'h0;
      m1_htrans = 2'b00;
      m1_hwrite = 1'b0;
      s_hready  = 1'b1;
      s_hresp   = 1'b0;
      for (int n = 1; n <= 18; n++) begin
         @(posedge clk);
         #1;
         check_val($sformatf("handover%0d core_rst_n", n), 32'(core_rst_n), 32'(n >= 18));
         check_val($sformatf("handover%0d m1_hready", n),  32'(m1_hready),  32'(n >= 18));
         check_val($sformatf("handover%0d s_htrans", n),   32'(s_htrans),   32'h0);
      end
      @(posedge clk);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         apply_stimulus(run_vecs[i]);
         #1;
         check_output(run_vecs[i], $sformatf("run%0d", i));
      end

      // Mid-run reset for one cycle during a core write.
      @(negedge clk);
      reset     = 1'b0;
      m0_haddr  = 32'h0;
      m0_htrans = 2'b00;
      m0_hwrite = 1'b0;
      m1_haddr  = 32'h300;
      m1_htrans = 2'b10;
      m1_hwrite = 1'b1;
      #1;
      check_val("rstlow s_htrans", 32'(s_htrans), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("rstexit s_htrans",   32'(s_htrans),   32'h0);
      check_val("rstexit core_rst_n", 32'(core_rst_n), 32'h0);
      check_val("rstexit m1_hready",  32'(m1_hready),  32'h0);
      check_val("rstexit prot_err",   32'(prot_err),   32'h0);
      check_val("rstexit s_haddr",    s_haddr,         32'h0);

      // Drain with a wait-stated final loader write: five stalled DRAIN cycles, then 1 + 16.
      @(negedge clk);
      boot_hold = 1'b1;
      m0_haddr  = 32'h8;
      m0_htrans = 2'b10;
      m0_hwrite = 1'b1;
      m1_htrans = 2'b00;
      s_hready  = 1'b1;
      @(negedge clk);
      m0_htrans = 2'b00;
      m0_hwrite = 1'b0;
      m0_hwdata = 32'hA5A5A5A5;
      boot_hold = 1'b0;
      s_hready  = 1'b0;
      for (int n = 1; n <= 23; n++) begin
         @(posedge clk);
         #1;
         check_val($sformatf("drain%0d core_rst_n", n), 32'(core_rst_n), 32'(n >= 23));
         if (n <= 6) begin
            check_val($sformatf("drain%0d s_htrans", n),  32'(s_htrans),  32'h0);
            check_val($sformatf("drain%0d s_hwdata", n),  s_hwdata,       32'hA5A5A5A5);
            check_val($sformatf("drain%0d m0_hready", n), 32'(m0_hready), 32'h0);
         end
         if (n == 6) begin
            s_hready = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
